// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: accepts parallel words over a valid/ready handshake, shifts
// them MSB-first through a Mealy pattern detector with a programmable pattern
// and overlap mode, and counts detections behind a sticky threshold interrupt.
//
// Handshake: a word transfers on any rising edge where word_valid and
// word_ready are both 1. A producer holds word_valid and word_in stable until
// that transfer. word_ready does not depend on word_valid.
module seq_det_ctrl #(
   parameter int WORD_W = 8,
   parameter int PAT_W  = 3,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [PAT_W-1:0]  cfg_pattern,
   input  logic              cfg_overlap,
   input  logic [WORD_W-1:0] word_in,
   input  logic              word_valid,
   output logic              word_ready,
   input  logic [CNT_W-1:0]  thresh,
   input  logic              cnt_clr,
   output logic              det_pulse,
   output logic [CNT_W-1:0]  det_count,
   output logic              irq,
   output logic              busy
);

   localparam int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int HIST_W = PAT_W - 1;
   localparam int FILL_W = $clog2(PAT_W);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [WORD_W-1:0]   shreg_q, shreg_d;
   logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
   logic [HIST_W-1:0]   hist_q, hist_d;
   logic [FILL_W-1:0]   fill_q, fill_d;
   logic [PAT_W-1:0]    pattern_q, pattern_d;
   logic                overlap_q, overlap_d;
   logic [CNT_W-1:0]    det_count_q, det_count_d;
   logic                irq_q, irq_d;

   logic                cur_bit;
   logic                last_bit;
   logic                hist_full;
   logic                accept;
   logic [PAT_W-1:0]    hist_cat;

   // Datapath taps; reset gates the handshake and detect strobes to 0.
   assign cur_bit    = shreg_q[bit_idx_q];
   assign last_bit   = (bit_idx_q == '0);
   assign hist_full  = (fill_q == FILL_W'(PAT_W - 1));
   assign hist_cat   = {hist_q, cur_bit};
   assign busy       = (state_q == SHIFT);
   assign word_ready = rst & ((state_q == IDLE) | (busy & last_bit));
   assign accept     = word_valid & word_ready;
   assign det_pulse  = rst & busy & hist_full & (hist_cat == pattern_q);
   assign det_count  = det_count_q;
   assign irq        = irq_q;

   // Sequencer next state: load a word, walk bit_idx down, reload at bit 0
   // when another word is offered so back-to-back words have no bubble.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_idx_d = bit_idx_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               shreg_d   = word_in;
               bit_idx_d = IDX_W'(WORD_W - 1);
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            if (last_bit) begin
               if (accept) begin
                  shreg_d   = word_in;
                  bit_idx_d = IDX_W'(WORD_W - 1);
               end else begin
                  state_d = IDLE;
               end
            end else begin
               bit_idx_d = bit_idx_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Detector history and configuration: history survives word boundaries and
   // idle gaps; a non-overlapping hit or a config load starts it afresh.
   always_comb begin
      hist_d    = hist_q;
      fill_d    = fill_q;
      pattern_d = pattern_q;
      overlap_d = overlap_q;
      if (busy) begin
         if (det_pulse && !overlap_q) begin
            hist_d = '0;
            fill_d = '0;
         end else begin
            hist_d = hist_cat[HIST_W-1:0];
            if (!hist_full) begin
               fill_d = fill_q + 1'b1;
            end
         end
      end else if (cfg_we) begin
         pattern_d = cfg_pattern;
         overlap_d = cfg_overlap;
         hist_d    = '0;
         fill_d    = '0;
      end
   end

   // Saturating detection counter and sticky interrupt; clear beats a hit.
   always_comb begin
      det_count_d = det_count_q;
      irq_d       = irq_q;
      if (cnt_clr) begin
         det_count_d = '0;
         irq_d       = 1'b0;
      end else if (det_pulse && (det_count_q != '1)) begin
         det_count_d = det_count_q + 1'b1;
         if ((thresh != '0) && (det_count_d == thresh)) begin
            irq_d = 1'b1;
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         bit_idx_q   <= '0;
         hist_q      <= '0;
         fill_q      <= '0;
         pattern_q   <= PAT_W'(3'b101);
         overlap_q   <= 1'b1;
         det_count_q <= '0;
         irq_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bit_idx_q   <= bit_idx_d;
         hist_q      <= hist_d;
         fill_q      <= fill_d;
         pattern_q   <= pattern_d;
         overlap_q   <= overlap_d;
         det_count_q <= det_count_d;
         irq_q       <= irq_d;
      end
   end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: drives seq_det_ctrl (CNT_W=8) and a CNT_W=2 copy from one
// stimulus stream and compares every cycle against a bit-stream model.
module tb_seq_det_ctrl;

   localparam int WORD_W = 8;
   localparam int PAT_W  = 3;

   // Clock / reset block
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, cfg_we, cfg_overlap, word_valid, cnt_clr;
   logic [2:0] cfg_pattern;
   logic [7:0] word_in, thresh;
   logic       word_ready, det_pulse, irq, busy;
   logic [7:0] det_count;
   logic       word_ready2, det_pulse2, irq2, busy2;
   logic [1:0] det_count2, thresh2;
   assign thresh2 = thresh[1:0];

   seq_det_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .cfg_overlap(cfg_overlap), .word_in(word_in), .word_valid(word_valid),
      .word_ready(word_ready), .thresh(thresh), .cnt_clr(cnt_clr),
      .det_pulse(det_pulse), .det_count(det_count), .irq(irq), .busy(busy)
   );

   seq_det_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .cfg_overlap(cfg_overlap), .word_in(word_in), .word_valid(word_valid),
      .word_ready(word_ready2), .thresh(thresh2), .cnt_clr(cnt_clr),
      .det_pulse(det_pulse2), .det_count(det_count2), .irq(irq2), .busy(busy2)
   );

   int vec_cnt  = 0;
   int miss_cnt = 0;

   // Reference model: bits still to send from the current word, the recent
   // bit history as a queue, config, and plain integer counters.
   int         m_rem = 0;
   logic [7:0] m_word = '0;
   bit         hist_q[$];
   logic [2:0] m_pat = 3'b101;
   bit         m_ovl = 1'b1;
   int         m_cnt8 = 0, m_cnt2 = 0;
   bit         m_irq8 = 1'b0, m_irq2 = 1'b0;
   bit         m_acc = 1'b0;

   // Scoreboard: {det, ready, busy, cnt8, irq8, cnt2, irq2}
   logic [14:0] exp_q[$];
   logic [14:0] obs_q[$];
   logic [7:0]  wq[$];

   function automatic bit model_det();
      int v = 0;
      if (!rst || m_rem == 0 || hist_q.size() != PAT_W - 1) return 1'b0;
      foreach (hist_q[i]) v = v * 2 + int'(hist_q[i]);
      v = v * 2 + int'(m_word[m_rem-1]);
      return v == int'(m_pat);
   endfunction

   function automatic bit model_ready();
      return rst && (m_rem <= 1);
   endfunction

   function automatic logic [14:0] exp_vec();
      return {model_det(), model_ready(), (m_rem > 0), 8'(m_cnt8), m_irq8,
              2'(m_cnt2), m_irq2};
   endfunction

   task automatic model_edge();
      bit det = model_det();
      bit rdy = model_ready();
      m_acc = 1'b0;
      if (!rst) begin
         m_rem = 0; hist_q.delete(); m_pat = 3'b101; m_ovl = 1'b1;
         m_cnt8 = 0; m_cnt2 = 0; m_irq8 = 1'b0; m_irq2 = 1'b0;
         return;
      end
      if (m_rem > 0) begin
         if (det && !m_ovl) hist_q.delete();
         else begin
            hist_q.push_back(m_word[m_rem-1]);
            if (hist_q.size() > PAT_W - 1) void'(hist_q.pop_front());
         end
         m_rem--;
      end else if (cfg_we) begin
         m_pat = cfg_pattern; m_ovl = cfg_overlap; hist_q.delete();
      end
      if (cnt_clr) begin
         m_cnt8 = 0; m_cnt2 = 0; m_irq8 = 1'b0; m_irq2 = 1'b0;
      end else if (det) begin
         if (m_cnt8 < 255) begin
            m_cnt8++;
            if (thresh != 0 && m_cnt8 == int'(thresh)) m_irq8 = 1'b1;
         end
         if (m_cnt2 < 3) begin
            m_cnt2++;
            if (thresh2 != 0 && m_cnt2 == int'(thresh2)) m_irq2 = 1'b1;
         end
      end
      if (word_valid && rdy) begin
         m_word = word_in; m_rem = WORD_W; m_acc = 1'b1;
      end
   endtask

   // Driver tasks: inputs change just after the falling edge, outputs are
   // sampled 1ns later, then the model follows the rising edge.
   task automatic cyc();
      #1;
      exp_q.push_back(exp_vec());
      obs_q.push_back({det_pulse, word_ready, busy, det_count, irq, det_count2, irq2});
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic do_cfg(input logic [2:0] pat, input bit ovl);
      cfg_we = 1'b1; cfg_pattern = pat; cfg_overlap = ovl;
      cyc();
      cfg_we = 1'b0;
   endtask

   task automatic do_clr();
      cnt_clr = 1'b1;
      cyc();
      cnt_clr = 1'b0;
   endtask

   task automatic send(input int gap_max, input bit clr_on_det, input int rst_at,
                       input int cfg_at, input bit rnd_ctl);
      int k = 0;
      while ((wq.size() > 0 || m_rem > 0) && k < 5000) begin
         if (!word_valid && wq.size() > 0)
            word_valid = (gap_max == 0) || ($urandom_range(0, gap_max) == 0);
         word_in = word_valid ? wq[0] : 8'($urandom);
         rst     = (k != rst_at);
         cfg_we  = (k == cfg_at);
         if (k == cfg_at) begin cfg_pattern = 3'b110; cfg_overlap = 1'b0; end
         if (rnd_ctl) begin
            cfg_we = ($urandom_range(0, 15) == 0);
            cfg_pattern = 3'($urandom); cfg_overlap = 1'($urandom);
            cnt_clr = ($urandom_range(0, 40) == 0);
         end
         if (clr_on_det) cnt_clr = model_det();
         cyc();
         if (m_acc) begin void'(wq.pop_front()); word_valid = 1'b0; end
         k++;
      end
      rst = 1'b1; cfg_we = 1'b0; cnt_clr = 1'b0; word_valid = 1'b0;
      cyc();
   endtask

   task automatic test_reset();
      logic [14:0] e, o;
      int n = 0;
      rst = 1'b0;
      @(posedge clk); model_edge(); @(negedge clk);
      cyc();
      rst = 1'b1;
      cyc();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vec_cnt++;
         if (o !== e) begin
            miss_cnt++;
            $display("FAIL reset cyc %0d: got %h expected %h", n, o, e);
         end
         n++;
      end
      vec_cnt++;
      if (det_count !== 8'd0 || irq !== 1'b0) begin
         miss_cnt++;
         $display("FAIL reset_counter: got cnt=%0d irq=%b expected cnt=0 irq=0", det_count, irq);
      end
   endtask

   task automatic test_default_detect();
      logic [14:0] e, o;
      int n = 0, pulses = 0, busy_cyc = 0, rdy_low = 0;
      wq.push_back(8'b1010_1000);
      send(0, 1'b0, -1, -1, 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vec_cnt++;
         if (o !== e) begin
            miss_cnt++;
            $display("FAIL default_detect cyc %0d: got %h expected %h", n, o, e);
         end
         pulses += int'(o[14]); busy_cyc += int'(o[12]);
         rdy_low += int'(o[12] & ~o[13]);
         n++;
      end
      vec_cnt++;
      if (det_count !== 8'd2 || pulses != 2 || busy_cyc != 8 || rdy_low != 7) begin
         miss_cnt++;
         $display("FAIL default_summary: got cnt=%0d pulses=%0d busy=%0d rdylow=%0d expected 2 2 8 7",
                  det_count, pulses, busy_cyc, rdy_low);
      end
   endtask

   task automatic test_overlap();
      logic [14:0] e, o;
      int n = 0;
      do_cfg(3'b101, 1'b0); do_clr();
      wq.push_back(8'b1010_1010);
      send(0, 1'b0, -1, -1, 1'b0);
      vec_cnt++;
      if (det_count !== 8'd2) begin
         miss_cnt++;
         $display("FAIL no_overlap_count: got %0d expected 2", det_count);
      end
      do_cfg(3'b101, 1'b1); do_clr();
      wq.push_back(8'b1010_1010);
      send(0, 1'b0, -1, -1, 1'b0);
      vec_cnt++;
      if (det_count !== 8'd3) begin
         miss_cnt++;
         $display("FAIL overlap_count: got %0d expected 3", det_count);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vec_cnt++;
         if (o !== e) begin
            miss_cnt++;
            $display("FAIL overlap cyc %0d: got %h expected %h", n, o, e);
         end
         n++;
      end
   endtask

   task automatic test_back_to_back();
      logic [14:0] e, o;
      int n = 0, busy_cyc = 0;
      do_cfg(3'b110, 1'b1); do_clr();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vec_cnt++;
         if (o !== e) begin
            miss_cnt++;
            $display("FAIL b2b_setup cyc %0d: got %h expected %h", n, o, e);
         end
      end
      wq.push_back(8'b0000_0001); wq.push_back(8'b1000_0000);
      send(0, 1'b0, -1, -1, 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vec_cnt++;
         if (o !== e) begin
            miss_cnt++;
            $display("FAIL back_to_back cyc %0d: got %h expected %h", n, o, e);
         end
         busy_cyc += int'(o[12]);
         n++;
      end
      vec_cnt++;
      if (det_count !== 8'd1 || busy_cyc != 16) begin
         miss_cnt++;
         $display("FAIL b2b_summary: got cnt=%0d busy=%0d expected cnt=1 busy=16", det_count, busy_cyc);
      end
   endtask

   task automatic test_irq();
      logic [14:0] e, o;
      int n = 0;
      do_cfg(3'b101, 1'b1); thresh = 8'd2; do_clr();
      wq.push_back(8'b1010_1000);
      send(0, 1'b0, -1, -1, 1'b0);
      wq.push_back(8'b1010_1000);
      send(0, 1'b0, -1, -1, 1'b0);
      vec_cnt++;
      if (irq !== 1'b1 || det_count !== 8'd4 || det_count2 !== 2'd3) begin
         miss_cnt++;
         $display("FAIL irq_sticky: got irq=%b cnt=%0d cnt2=%0d expected 1 4 3", irq, det_count, det_count2);
      end
      wq.push_back(8'b1010_0000);
      send(0, 1'b1, -1, -1, 1'b0);
      vec_cnt++;
      if (irq !== 1'b0 || det_count !== 8'd0) begin
         miss_cnt++;
         $display("FAIL clr_vs_det: got irq=%b cnt=%0d expected 0 0", irq, det_count);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vec_cnt++;
         if (o !== e) begin
            miss_cnt++;
            $display("FAIL irq cyc %0d: got %h expected %h", n, o, e);
         end
         n++;
      end
      thresh = 8'd0;
   endtask

   task automatic test_mid_reset_and_cfg();
      logic [14:0] e, o;
      int n = 0;
      do_cfg(3'b110, 1'b0);
      wq.push_back(8'b1010_1000);
      send(0, 1'b0, 4, -1, 1'b0);
      vec_cnt++;
      if (busy !== 1'b0 || det_count !== 8'd0) begin
         miss_cnt++;
         $display("FAIL mid_reset: got busy=%b cnt=%0d expected 0 0", busy, det_count);
      end
      wq.push_back(8'b1010_1000);
      send(0, 1'b0, -1, 2, 1'b0);
      vec_cnt++;
      if (det_count !== 8'd2) begin
         miss_cnt++;
         $display("FAIL cfg_while_busy: got cnt=%0d expected 2", det_count);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vec_cnt++;
         if (o !== e) begin
            miss_cnt++;
            $display("FAIL mid_reset cyc %0d: got %h expected %h", n, o, e);
         end
         n++;
      end
   endtask

   task automatic test_saturate();
      logic [14:0] e, o;
      int n = 0;
      do_cfg(3'b111, 1'b1); do_clr();
      for (int i = 0; i < 40; i++) wq.push_back(8'hFF);
      send(0, 1'b0, -1, -1, 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vec_cnt++;
         if (o !== e) begin
            miss_cnt++;
            $display("FAIL saturate cyc %0d: got %h expected %h", n, o, e);
         end
         n++;
      end
      vec_cnt++;
      if (det_count !== 8'd255 || det_count2 !== 2'd3) begin
         miss_cnt++;
         $display("FAIL saturate_final: got cnt=%0d cnt2=%0d expected 255 3", det_count, det_count2);
      end
   endtask

   task automatic test_random();
      logic [14:0] e, o;
      int n = 0;
      for (int r = 0; r < 4; r++) begin
         do_cfg(3'($urandom), 1'($urandom));
         thresh = 8'($urandom_range(0, 6));
         do_clr();
         for (int i = 0; i < 40; i++) wq.push_back(8'($urandom));
         send(3, 1'b0, -1, -1, 1'b1);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vec_cnt++;
         if (o !== e) begin
            miss_cnt++;
            $display("FAIL random cyc %0d: got %h expected %h", n, o, e);
         end
         n++;
      end
      thresh = 8'd0;
   endtask

   // Test sequence and final report
   initial begin
      rst = 1'b0; cfg_we = 1'b0; cfg_pattern = 3'b000; cfg_overlap = 1'b0;
      word_in = 8'h00; word_valid = 1'b0; thresh = 8'd0; cnt_clr = 1'b0;
      @(negedge clk);
      test_reset();
      test_default_detect();
      test_overlap();
      test_back_to_back();
      test_irq();
      test_mid_reset_and_cfg();
      test_saturate();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
